// File: rtl/uart_tx_async_pkg.sv
// Shared types and constants for the asynchronous UART transmitter.
// Frame parity helper lives here so load logic and any checker agree on it.
package uart_tx_async_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam logic [3:0]  TICK_LAST     = 4'(TICKS_PER_BIT - 1);

  localparam int unsigned DATA_BITS_7 = 7;
  localparam int unsigned DATA_BITS_8 = 8;
  localparam logic [2:0]  LAST_BIT_7  = 3'(DATA_BITS_7 - 1);
  localparam logic [2:0]  LAST_BIT_8  = 3'(DATA_BITS_8 - 1);

  // In 7-bit mode the MSB is never sent, so it must not affect parity.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic       use_bit8,
                                        input logic       odd);
    logic [7:0] sent;
    if (use_bit8) begin
      sent = data;
    end else begin
      sent = {1'b0, data[6:0]};
    end
    return (^sent) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_async_hold_ctrl.sv
// Transmit holding register: written directly by the register block, or
// fetched from an external registered-output TX FIFO when TX_FIFO=1.
module uart_tx_hold_ctrl
  import uart_tx_async_pkg::*;
#(
  parameter int unsigned TX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_tx_byte_i,
  input  logic [7:0] tx_data_i,
  input  logic       fifo_empty_i,
  input  logic       idle_i,
  input  logic       take_i,
  output logic [7:0] hold_data_o,
  output logic       hold_full_o,
  output logic       tx_hold_empty_o,
  output logic       fifo_read_n_o
);

  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       read_n_q, read_n_d;
  logic       fetch_pend_q, fetch_pend_d;

  // Next-state for the holding register and the FIFO fetch handshake.
  always_comb begin
    hold_d       = hold_q;
    full_d       = full_q;
    empty_d      = empty_q;
    read_n_d     = 1'b1;
    fetch_pend_d = ~read_n_q;
    if (take_i) begin
      full_d  = 1'b0;
      empty_d = 1'b1;
    end else if (TX_FIFO == 0) begin
      if (write_tx_byte_i && empty_q) begin
        hold_d  = tx_data_i;
        full_d  = 1'b1;
        empty_d = 1'b0;
      end else begin
        hold_d  = hold_q;
      end
    end else begin
      // FIFO data appears one clk after the strobe, hence the pending stage.
      if (fetch_pend_q) begin
        hold_d = tx_data_i;
        full_d = 1'b1;
      end else if (idle_i && empty_q && !fifo_empty_i) begin
        read_n_d = 1'b0;
        empty_d  = 1'b0;
      end else begin
        read_n_d = 1'b1;
      end
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q       <= 8'h00;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      read_n_q     <= 1'b1;
      fetch_pend_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      read_n_q     <= read_n_d;
      fetch_pend_q <= fetch_pend_d;
    end
  end

  assign hold_data_o     = hold_q;
  assign hold_full_o     = full_q;
  assign tx_hold_empty_o = empty_q;
  assign fifo_read_n_o   = read_n_q;

endmodule

// File: rtl/uart_tx_async.sv
// Asynchronous UART transmitter: start, 7/8 data bits LSB-first, optional
// parity, one stop bit; bit timing from a 16x baud_clock pulse.
module uart_tx_async
  import uart_tx_async_pkg::*;
#(
  parameter int unsigned TX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       write_tx_byte,
  input  logic [7:0] tx_data,
  input  logic       fifo_empty,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_hold_empty,
  output logic       tx_busy
);

  tx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       bit8_q, bit8_d;
  logic       par_en_q, par_en_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       busy_q;

  logic [7:0] hold_data_s;
  logic       hold_full_s;
  logic       bit_end_s;
  logic       take_s;
  logic [2:0] last_bit_s;

  uart_tx_hold_ctrl #(
    .TX_FIFO (TX_FIFO)
  ) u_hold (
    .clk             (clk),
    .reset_n         (reset_n),
    .write_tx_byte_i (write_tx_byte),
    .tx_data_i       (tx_data),
    .fifo_empty_i    (fifo_empty),
    .idle_i          (state_q == ST_IDLE),
    .take_i          (take_s),
    .hold_data_o     (hold_data_s),
    .hold_full_o     (hold_full_s),
    .tx_hold_empty_o (tx_hold_empty),
    .fifo_read_n_o   (fifo_read_n)
  );

  assign bit_end_s  = baud_clock && (tick_q == TICK_LAST);
  assign last_bit_s = bit8_q ? LAST_BIT_8 : LAST_BIT_7;
  // A pending byte is taken either from IDLE or at the end of STOP (no gap).
  assign take_s     = hold_full_s &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end_s));

  // Frame sequencer: load on transfer, otherwise advance on baud pulses.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit8_d    = bit8_q;
    par_en_d  = par_en_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    if (take_s) begin
      shift_d   = hold_data_s;
      bit8_d    = bit8;
      par_en_d  = parity_en;
      parity_d  = frame_parity(hold_data_s, bit8, odd_n_even);
      state_d   = ST_START;
      tick_d    = 4'd0;
      bit_cnt_d = 3'd0;
      if (baud_clock) begin
        tx_d = 1'b1;
      end else begin
        tx_d = tx_q;
      end
    end else if (baud_clock) begin
      if (state_q != ST_IDLE) begin
        tick_d = tick_q + 4'd1;
      end else begin
        tick_d = 4'd0;
      end
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
        end
        ST_START: begin
          tx_d = 1'b0;
          if (bit_end_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = ST_START;
          end
        end
        ST_DATA: begin
          tx_d = shift_q[0];
          if (bit_end_s) begin
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_cnt_q == last_bit_s) begin
              state_d   = par_en_q ? ST_PARITY : ST_STOP;
              bit_cnt_d = 3'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_PARITY: begin
          tx_d = parity_q;
          if (bit_end_s) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          tx_d = 1'b1;
          if (bit_end_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = 4'd0;
          tx_d    = 1'b1;
        end
      endcase
    end else begin
      tx_d = tx_q;
    end
  end

  // Sequencer registers; tx and busy are registered so the pad never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      bit8_q    <= 1'b0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bit8_q    <= bit8_d;
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Scoreboard bench: stimulus pushes hand-computed frames, a monitor decodes
// the serial line at each baud pulse and compares against them.
module tb_uart_tx_async;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
    bit          b2b;
  } exp_t;

  logic clk, reset_n, baud_clock;
  logic bit8, parity_en, odd_n_even;
  logic write_tx_byte;
  logic [7:0] tx_data;
  logic m_fifo_empty;
  logic fifo_read_n, tx, tx_hold_empty, tx_busy;
  logic [7:0] f_tx_data;
  logic f_fifo_empty;
  logic f_fifo_read_n, f_tx, f_tx_hold_empty, f_tx_busy;

  exp_t exp_q[$];
  logic [7:0] fifo_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit sel_fifo = 1'b0;
  bit m_active = 1'b0;
  int strobes = 0;
  int low_cyc = 0;

  uart_tx_async #(.TX_FIFO(0)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .write_tx_byte(write_tx_byte),
    .tx_data(tx_data), .fifo_empty(m_fifo_empty), .fifo_read_n(fifo_read_n),
    .tx(tx), .tx_hold_empty(tx_hold_empty), .tx_busy(tx_busy)
  );

  uart_tx_async #(.TX_FIFO(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .write_tx_byte(write_tx_byte),
    .tx_data(f_tx_data), .fifo_empty(f_fifo_empty), .fifo_read_n(f_fifo_read_n),
    .tx(f_tx), .tx_hold_empty(f_tx_hold_empty), .tx_busy(f_tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk baud pulse every 4 clks, changed 2 time units after posedge.
  initial begin
    int div;
    div = 0;
    baud_clock = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      div = (div == 3) ? 0 : div + 1;
      baud_clock = (div == 0);
    end
  end

  // Registered-output FIFO model: data updates just after the clk ending the strobe.
  initial begin
    f_fifo_empty = 1'b1;
    f_tx_data = 8'h00;
    forever begin
      @(negedge clk);
      f_fifo_empty = (fifo_q.size() == 0);
      if (f_fifo_read_n === 1'b0) begin
        @(posedge clk);
        #1;
        if (fifo_q.size() > 0) f_tx_data = fifo_q.pop_front();
      end
    end
  end

  initial begin
    logic prev_rn;
    prev_rn = 1'b1;
    forever begin
      @(negedge clk);
      if (f_fifo_read_n === 1'b0) begin
        low_cyc++;
        if (prev_rn) strobes++;
      end
      prev_rn = f_fifo_read_n;
    end
  end

  // Monitor: samples the selected line once per consumed baud pulse.
  initial begin
    exp_t cur;
    bit   prev_baud, nochk, stable;
    logic val, mtx;
    int   pulse, last_end, bitn, tick, frame;
    prev_baud = 1'b0; pulse = 0; last_end = -100; frame = 0;
    bitn = 0; tick = 0; nochk = 1'b0; stable = 1'b1; val = 1'b1;
    cur = '{bits: 11'd0, nbits: 10, b2b: 1'b0};
    forever begin
      @(negedge clk);
      mtx = sel_fifo ? f_tx : tx;
      if (!reset_n || !mon_en) begin
        m_active = 1'b0;
        prev_baud = 1'b0;
        last_end = -100;
      end else begin
        if (prev_baud) begin
          pulse++;
          if (!m_active && mtx === 1'b0) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_fail++; nochk = 1'b1;
              cur = '{bits: 11'd0, nbits: 10, b2b: 1'b0};
              $display("FAIL unexpected_frame: start bit at pulse %0d, required no frame", pulse);
            end else begin
              cur = exp_q.pop_front();
              nochk = 1'b0;
              if (cur.b2b) begin
                n_cmp++;
                if (pulse != last_end + 1) begin
                  n_fail++;
                  $display("FAIL b2b_gap frame%0d: %0d idle pulses, required 0", frame, pulse - last_end - 1);
                end
              end
            end
            m_active = 1'b1; bitn = 0; tick = 0;
          end
          if (m_active) begin
            if (tick == 0) begin
              val = mtx; stable = 1'b1;
            end else if (mtx !== val) begin
              stable = 1'b0;
            end
            tick++;
            if (tick == 16) begin
              if (!nochk) begin
                n_cmp++;
                if (!stable || val !== cur.bits[bitn]) begin
                  n_fail++;
                  $display("FAIL frame%0d_bit%0d: got %b (stable=%0d), required %b for 16 pulses",
                           frame, bitn, val, stable, cur.bits[bitn]);
                end
              end
              tick = 0; bitn++;
              if (bitn == cur.nbits) begin
                m_active = 1'b0; last_end = pulse; frame++;
              end
            end
          end
        end
        prev_baud = baud_clock;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic cfg(input logic b8, input logic pe, input logic odd);
    @(negedge clk);
    bit8 = b8; parity_en = pe; odd_n_even = odd;
  endtask

  task automatic pulse_write(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; write_tx_byte = 1'b1;
    @(negedge clk);
    write_tx_byte = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] bits, input int nb, input bit b2b);
    exp_q.push_back('{bits: bits, nbits: nb, b2b: b2b});
    pulse_write(d);
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_active || (sel_fifo ? f_tx_busy : tx_busy)) && i < 3000) begin
      @(negedge clk); i++;
    end
    n_cmp++;
    if (i >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d frames still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic count_busy(input string name, input int req);
    int i, n;
    i = 0; n = 0;
    while (!tx_busy && i < 10) begin @(negedge clk); i++; end
    while (tx_busy && i < 3000) begin
      if (baud_clock) n++;
      @(negedge clk); i++;
    end
    check(name, n, req);
  endtask

  initial begin
    reset_n = 1'b0; write_tx_byte = 1'b0; tx_data = 8'h00; m_fifo_empty = 1'b1;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1); check("rst_hold_empty", tx_hold_empty, 1);
    check("rst_busy", tx_busy, 0); check("rst_fifo_read_n", fifo_read_n, 1);
    check("rst_f_tx", f_tx, 1); check("rst_f_read_n", f_fifo_read_n, 1);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 8N1 0xA5 with hold-empty timing and busy length.
    cfg(1'b1, 1'b0, 1'b0);
    send(8'hA5, 10'b1_10100101_0, 10, 1'b0);
    check("8n1_hold_empty_after_write", tx_hold_empty, 0);
    @(negedge clk);
    check("8n1_hold_empty_reassert", tx_hold_empty, 1);
    check("8n1_busy_after_transfer", tx_busy, 1);
    check("8n1_tx_before_first_pulse", tx, 1);
    count_busy("8n1_busy_pulses", 160);
    wait_done("8n1_a5");

    // 7-bit parity cases; bit 7 must not affect parity.
    cfg(1'b0, 1'b1, 1'b0);
    send(8'h41, 10'b1_0_1000001_0, 10, 1'b0); wait_done("7e1_41");
    cfg(1'b0, 1'b1, 1'b1);
    send(8'h41, 10'b1_1_1000001_0, 10, 1'b0); wait_done("7o1_41");
    cfg(1'b0, 1'b1, 1'b0);
    send(8'hC1, 10'b1_0_1000001_0, 10, 1'b0); wait_done("7e1_c1");

    // 8-bit parity cases; 8E1 frame is 176 pulses.
    cfg(1'b1, 1'b1, 1'b1);
    send(8'h00, 11'b1_1_00000000_0, 11, 1'b0); wait_done("8o1_00");
    cfg(1'b1, 1'b1, 1'b0);
    send(8'hFF, 11'b1_0_11111111_0, 11, 1'b0);
    @(negedge clk);
    count_busy("8e1_busy_pulses", 176);
    wait_done("8e1_ff");

    // Back-to-back; a third write while hold is full is dropped.
    cfg(1'b1, 1'b0, 1'b0);
    send(8'h12, 10'b1_00010010_0, 10, 1'b0);
    repeat (120) @(negedge clk);
    send(8'h34, 10'b1_00110100_0, 10, 1'b1);
    check("b2b_hold_full", tx_hold_empty, 0);
    pulse_write(8'h99);
    check("b2b_third_ignored_hold", tx_hold_empty, 0);
    wait_done("b2b");
    repeat (200) @(negedge clk);
    check("b2b_idle_after", tx, 1);

    // Reset in the middle of DATA discards both the frame and the held byte.
    mon_en = 1'b0;
    pulse_write(8'h3C);
    repeat (120) @(negedge clk);
    pulse_write(8'h77);
    check("rstmid_hold_full", tx_hold_empty, 0);
    check("rstmid_busy", tx_busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1); check("rstmid_hold_empty", tx_hold_empty, 1);
    check("rstmid_busy_clr", tx_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'h55, 10'b1_01010101_0, 10, 1'b0);
    wait_done("rstmid_55");
    repeat (200) @(negedge clk);

    check("fifo_inst_ignores_write_hold", f_tx_hold_empty, 1);
    check("fifo_inst_ignores_write_busy", f_tx_busy, 0);
    check("fifo_inst_no_strobe_yet", strobes, 0);

    // FIFO mode: two bytes, one strobe each.
    sel_fifo = 1'b1;
    exp_q.push_back('{bits: 11'b1_01011010_0, nbits: 10, b2b: 1'b0});
    exp_q.push_back('{bits: 11'b1_01011010_0, nbits: 10, b2b: 1'b0});
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h5A);
    wait_done("fifo_5a");
    check("fifo_strobes", strobes, 2);
    check("fifo_strobe_low_clks", low_cyc, 2);

    // FIFO empty: no strobe, line stays idle.
    begin
      bit saw_low;
      saw_low = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (f_tx !== 1'b1) saw_low = 1'b1;
      end
      check("fifo_empty_no_strobe", strobes, 2);
      check("fifo_empty_tx_idle_low_seen", saw_low, 0);
      check("fifo_empty_hold_empty", f_tx_hold_empty, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_async.md
Name: uart_tx_async

Overview:
- Asynchronous UART transmitter; mirror of the UART receiver in the same CoreUART/CoreUARTapb core.
- Serialises one character per frame: start bit, 7 or 8 data bits LSB-first, optional even/odd parity, one stop bit.
- Bit timing comes from the shared baud_clock pulse (16 pulses per bit), the same pulse that drives the receiver.
- Sits between the APB register block (or TX FIFO) and the tx pad.

Parameters:
- TX_FIFO, 0: 0 = single holding register written by write_tx_byte; 1 = byte pulled from an external TX FIFO via fifo_read_n/fifo_empty.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- baud_clock  in  1  one-clk pulse, 16 per bit period
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  1 = parity bit appended
- odd_n_even  in  1  1 = odd parity, 0 = even parity
- write_tx_byte  in  1  one-clk write strobe for tx_data (TX_FIFO=0 only)
- tx_data  in  8  byte to send (register data, or FIFO read data)
- fifo_empty  in  1  TX FIFO empty (TX_FIFO=1 only)
- fifo_read_n  out  1  active-low one-clk FIFO read strobe
- tx  out  1  serial line, idle high
- tx_hold_empty  out  1  holding register empty (TXRDY)
- tx_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset values: tx=1, tx_hold_empty=1, tx_busy=0, fifo_read_n=1; state=IDLE; all counters and registers 0.
- Holding register, TX_FIFO=0:
  - write_tx_byte while tx_hold_empty=1: latch tx_data, clear tx_hold_empty next clk.
  - write_tx_byte while tx_hold_empty=0: ignored; held byte is unchanged.
- Holding register, TX_FIFO=1:
  - In IDLE with hold empty and fifo_empty=0: drive fifo_read_n=0 for exactly 1 clk.
  - Latch tx_data on the following clk (FIFO output is registered); tx_hold_empty is 0 from the strobe until the hold register is transferred.
  - write_tx_byte is ignored.
- Transfer: in IDLE with hold full, on the next clk:
  - copy byte into the shift register;
  - sample bit8, parity_en and odd_n_even into frame-config registers;
  - set tx_hold_empty=1 on the same clk;
  - enter START, tick_cnt=0.
  - Config changes mid-frame have no effect on the current frame.
- State and counter updates happen only on clk edges where baud_clock=1, except the load/transfer logic above.
- tick_cnt (4 bits) increments each baud_clock while state != IDLE and wraps 15->0. The wrap marks the end of a bit.
- START: tx=0. On wrap -> DATA, bit_cnt=0.
- DATA: tx=shift[0]. On wrap, shift right and increment bit_cnt.
  - Last data bit is bit_cnt 7 (8-bit mode) or 6 (7-bit mode).
  - After the last data bit -> PARITY if parity_en, else STOP.
- Parity bit:
  - even = XOR of the transmitted data bits;
  - odd = inverse of that XOR;
  - in 7-bit mode tx_data[7] is excluded.
  - Accumulate it during DATA, or compute it at load; the result must match either way.
- PARITY: tx=parity bit. On wrap -> STOP.
- STOP: tx=1. On wrap:
  - if hold is full, go straight to START with no idle gap (back-to-back);
  - otherwise -> IDLE.
- tx is a registered output: glitch-free, and changes only on baud_clock edges or reset.
- Frame length = (1 + data bits + parity + 1) x 16 baud_clock pulses; 8N1 = 160 pulses.
- Latency: tx falls on the first baud_clock pulse after the transfer clk.
- Reset mid-frame: tx returns to 1 immediately (async) and the held byte is discarded.

Decomposition:
- Shared package:
  - state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits;
  - TICKS_PER_BIT=16;
  - data-width constants 7 and 8.
- Sub-module uart_tx_hold_ctrl holds the holding register, tx_hold_empty, and the TX_FIFO-dependent fetch logic.
- Shifter, counters and FSM stay in the top module.

Test Plan:
- 8N1, write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 16 baud pulses; tx_hold_empty re-asserts 1 clk after the write; tx_busy high for 160 pulses.
- 7E1, write 0x41 -> data bits 1000001, parity=0, stop=1; 7O1 with 0x41 -> parity=1; tx_data[7]=1 in 7-bit mode does not change parity.
- 8O1, write 0x00 -> parity bit 1; 8E1 with 0xFF -> parity bit 0; frame is 176 pulses.
- Back-to-back: second write during the first frame's DATA state -> STOP followed immediately by START with no idle pulses; a third write while hold is full is ignored.
- Reset asserted during the DATA state of frame 0x3C -> tx=1 and tx_hold_empty=1 at once; after release, a new write of 0x55 transmits cleanly.
- TX_FIFO=1, fifo_empty=0 with data 0x5A -> one 1-clk fifo_read_n low pulse per frame; with fifo_empty=1 -> no strobe, tx stays 1.
